// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   640x480@60Hz VGA timing generator. Divides clk down to the pixel rate,
//   runs the horizontal/vertical counters and presents them as xCoord/yCoord
//   to the pixel-colour logic. It then registers the returned colour onto the
//   VGA pins together with hsync/vsync, one pixel period later.
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   When defined, a test_mode input is added. When test_mode=1, rgb_in is
//   replaced by eight 80-pixel-wide colour bars.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          synchronous, active-high reset
//   test_mode    (VGA_TEST_PATTERN_EN only) select built-in colour bars
//   rgb_in       pixel colour {blue[1:0], green[2:0], red[2:0]}
//   xCoord       horizontal count, 0..H_TOTAL-1
//   yCoord       vertical count, 0..V_TOTAL-1
//   pixel_tick   strobe on the last clk of each pixel period
//   video_on     current coordinates are inside the visible area
//   frame_start  one-clk pulse on the tick that wraps the counters to (0,0)
//   hsync/vsync  registered sync outputs, active level SYNC_ACTIVE
//   vga_red/vga_green/vga_blue  registered colour, zero during blanking

module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    input  logic [7:0] rgb_in,
    output logic [9:0] xCoord,
    output logic [9:0] yCoord,
    output logic       pixel_tick,
    output logic       video_on,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] vga_red,
    output logic [2:0] vga_green,
    output logic [1:0] vga_blue
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [4:0] DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [4:0] div;
    logic [9:0] h;
    logic [9:0] v;
    logic       h_last;
    logic       v_last;
    logic       hs_raw;
    logic       vs_raw;
    logic [7:0] pix_colour;

    // With CLK_DIV=1, DIV_LAST is 0 and div never leaves 0, so the tick is
    // held high.
    assign pixel_tick  = (div == DIV_LAST);
    assign h_last      = (h == H_LAST);
    assign v_last      = (v == V_LAST);
    assign frame_start = pixel_tick && h_last && v_last;

    assign xCoord   = h;
    assign yCoord   = v;
    assign video_on = (h < H_VIS) && (v < V_VIS);
    assign hs_raw   = (h >= HS_START) && (h < HS_END);
    assign vs_raw   = (v >= VS_START) && (v < VS_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (pixel_tick) begin
            div <= '0;
        end else begin
            div <= div + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pixel_tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_idx;
    logic [7:0] bar_colour;

    // Bars are 80 px wide; only indices 0..7 occur inside the visible area.
    assign bar_idx = 3'(h / 10'd80);

    always_comb begin
        bar_colour = '0;
        case (bar_idx)
            3'd0: bar_colour = 8'hFF;
            3'd1: bar_colour = 8'h3F;
            3'd2: bar_colour = 8'hF8;
            3'd3: bar_colour = 8'h38;
            3'd4: bar_colour = 8'hC7;
            3'd5: bar_colour = 8'h07;
            3'd6: bar_colour = 8'hC0;
            default: bar_colour = 8'h00;
        endcase
    end
`endif

    always_comb begin
        pix_colour = rgb_in;
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
            pix_colour = bar_colour;
        end
`endif
        if (!video_on) begin
            pix_colour = '0;
        end
    end

    // Sync and colour are captured on the same tick edge, so the pins show
    // the pixel whose coordinates were presented during the previous period.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync     <= ~SYNC_ACTIVE;
            vsync     <= ~SYNC_ACTIVE;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else if (pixel_tick) begin
            hsync     <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync     <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga_red   <= pix_colour[2:0];
            vga_green <= pix_colour[5:3];
            vga_blue  <= pix_colour[7:6];
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen using a reduced screen geometry so that whole
//   frames fit in a short run: 16+2+3+2 = 23 pixels per line,
//   6+1+2+1 = 10 lines per frame, 4 clks per pixel.
//   hsync is active for x=18..20, vsync for y=7..8 (active low).

module tb_vga_timing_gen;

    localparam int CD = 4;
    localparam int HV = 16, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = 23;
    localparam int VT = 10;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rgb_in = 8'h00;
    logic [9:0] xCoord, yCoord;
    logic       pixel_tick, video_on, frame_start, hsync, vsync;
    logic [2:0] vga_red, vga_green;
    logic [1:0] vga_blue;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode = 1'b0;
`endif

    vga_timing_gen #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .rgb_in(rgb_in), .xCoord(xCoord), .yCoord(yCoord),
        .pixel_tick(pixel_tick), .video_on(video_on), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        bit         von;
        bit         fs;
        bit         hs;
        bit         vs;
        logic [7:0] col;
    } exp_t;

    exp_t sb[$];
    exp_t prev;          // pins expected at the next tick
    int   checks   = 0;
    int   failures = 0;
    int   hrun = 0, vrun = 0, fs_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [7:0] rgb);
        exp_t e;
        int   p;
        p     = k % FRAME;
        e.x   = p % HT;
        e.y   = p / HT;
        e.von = (e.x < HV) && (e.y < VV);
        e.fs  = (e.x == HT - 1) && (e.y == VT - 1);
        e.hs  = !((e.x >= 18) && (e.x <= 20));
        e.vs  = !((e.y >= 7) && (e.y <= 8));
        e.col = e.von ? rgb : 8'h00;
        return e;
    endfunction

    function automatic exp_t idle_pins();
        exp_t e;
        e = mk(0, 8'h00);
        e.hs = 1'b1; e.vs = 1'b1; e.col = 8'h00;
        return e;
    endfunction

    function automatic logic [7:0] vec_rgb(input int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    // Called at div==0 (+1ns) of pixel k; leaves at div==0 of pixel k+1.
    task automatic run_pixel(input int k, input logic [7:0] rgb);
        rgb_in = rgb;
        sb.push_back(mk(k, rgb));
        repeat (CD) @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_x"}, 32'(xCoord), 0);
        chk({tag, "_y"}, 32'(yCoord), 0);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_colour"}, 32'({vga_blue, vga_green, vga_red}), 0);
        chk({tag, "_frame_start"}, 32'(frame_start), 0);
        chk({tag, "_tick"}, 32'(pixel_tick), 0);
        chk({tag, "_video_on"}, 32'(video_on), 1);
    endtask

    // Monitor: pops one expectation per pixel_tick.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hrun = 0;
            vrun = 0;
        end else if (!pixel_tick) begin
            chk("frame_start_off_tick", 32'(frame_start), 0);
        end else if (sb.size() == 0) begin
            chk("tick_without_stimulus", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk("xCoord", 32'(xCoord), 32'(e.x));
            chk("yCoord", 32'(yCoord), 32'(e.y));
            chk("video_on", 32'(video_on), 32'(e.von));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("hsync", 32'(hsync), 32'(prev.hs));
            chk("vsync", 32'(vsync), 32'(prev.vs));
            chk("colour", 32'({vga_blue, vga_green, vga_red}), 32'(prev.col));
            if (frame_start) fs_seen++;
            if (!hsync) hrun++;
            else begin
                if (hrun != 0) chk("hsync_width", 32'(hrun), HS);
                hrun = 0;
            end
            if (!vsync) vrun++;
            else begin
                if (vrun != 0) chk("vsync_width", 32'(vrun), VS * HT);
                vrun = 0;
            end
            prev = e;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k_rst;
        prev = idle_pins();
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;

        // Frame A: constant colour 01_111_000 for one frame, then varying
        // colours into the next frame up to (x=12, y=4).
        for (int k = 0; k < FRAME; k++) run_pixel(k, 8'b0111_1000);
        k_rst = FRAME + 4 * HT + 12;
        for (int k = FRAME; k < k_rst; k++) run_pixel(k, vec_rgb(k));

        // Mid-frame reset at div==2 of pixel (12,4).
        rgb_in = vec_rgb(k_rst);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("midreset");
        chk("midreset_sb_empty", 32'(sb.size()), 0);
        sb.delete();
        prev = idle_pins();
        rst  = 1'b0;

        // Frame B: full frame plus one line to see the wrap.
        for (int k = 0; k < FRAME + HT; k++) run_pixel(k, vec_rgb(k + 5));

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        chk("frame_start_count", 32'(fs_seen), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
